// File: rtl/sram_arbiter_pkg.sv
// Shared defaults and grant encoding for the SRAM arbiter.
// SRAM_WORD / MAX_T_SIZE_LOG mirror the legacy `Sram_Word / `Max_T_size_log defines.
package sram_arbiter_pkg;
  localparam int SRAM_WORD           = 16;
  localparam int MAX_T_SIZE_LOG      = 8;
  localparam int READ_STREAK_DEFAULT = 4;
  localparam int WFIFO_DEPTH_DEFAULT = 4;

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_LOAD  = 2'd1;
  localparam logic [1:0] GNT_STORE = 2'd2;
  localparam logic [1:0] GNT_READ  = 2'd3;
endpackage

// File: rtl/sram_arbiter_wr_fifo.sv
// Store queue for the arbiter: synchronous FIFO of {addr, data} with synchronous clear.
// A push while full is accepted only when a pop happens in the same cycle.
module sram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         almost_full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  assign full        = (cnt == FULL_CNT);
  assign almost_full = (cnt >= AF_CNT);
  assign empty       = (cnt == '0);
  assign head        = mem[rd_idx];
endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: loader, queued stores and sequential reads share one port,
// one registered command per cycle, read data returned in order three cycles after the pulse.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = MAX_T_SIZE_LOG,
  parameter int WORD_W      = SRAM_WORD,
  parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEFAULT,
  parameter int READ_STREAK = READ_STREAK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic              i_load_mode,
  input  logic [ADDR_W-1:0] i_word_count,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [WORD_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  input  logic              i_rd_req,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr_req,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [WORD_W-1:0] o_sram_d,
  input  logic [WORD_W-1:0] i_sram_q,
  output logic              o_busy,
  output logic              o_overflow
);
  localparam int SW = $clog2(READ_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(READ_STREAK);

  logic [ADDR_W-1:0]        rd_ptr;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [1:0]               rd_pend;
  logic [SW-1:0]            streak;
  logic                     full;
  logic                     almost_full;
  logic                     empty;
  logic [ADDR_W+WORD_W-1:0] head;
  logic [ADDR_W-1:0]        head_addr;
  logic [WORD_W-1:0]        head_data;
  logic [1:0]               gnt;
  logic                     push;
  logic                     pop;
  logic                     rd_inc;
  logic                     rd_dec;
  logic                     ovf_now;
  logic                     rd_vld_p0;

  // A bound of 0 lets the pointer run the full 2^ADDR_W range.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W-1:0] bound);
    if (bound != '0 && p == bound - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  assign {head_addr, head_data} = head;

  always_comb begin
    gnt = GNT_IDLE;
    if (!i_init) begin
      if (i_load_mode) begin
        if (i_ld_valid) gnt = GNT_LOAD;
      end else if (!empty && (rd_pend == 2'd0 || almost_full ||
                              streak >= STREAK_MAX || head_addr == rd_ptr)) begin
        gnt = GNT_STORE;
      end else if (rd_pend != 2'd0) begin
        gnt = GNT_READ;
      end
    end
  end

  assign pop        = (gnt == GNT_STORE);
  assign rd_dec     = (gnt == GNT_READ);
  assign push       = i_wr_req && !i_init && (!full || pop);
  assign rd_inc     = i_rd_req && !i_init && (rd_pend != 2'd3 || rd_dec);
  assign ovf_now    = !i_init && ((i_wr_req && full && !pop) ||
                                  (i_rd_req && rd_pend == 2'd3 && !rd_dec));
  assign o_ld_ready = (gnt == GNT_LOAD);
  assign o_busy     = (rd_pend != 2'd0) || !empty || rd_vld_p0 || !o_sram_cen;

  sram_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .W     (ADDR_W + WORD_W)
  ) u_wr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (i_init),
    .push        (push),
    .pop         (pop),
    .din         ({wr_ptr, i_wr_data}),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .head        (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_pend    <= '0;
      streak     <= '0;
      o_overflow <= 1'b0;
    end else if (i_init) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_pend    <= '0;
      streak     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr, i_word_count);
      if (rd_dec) rd_ptr <= next_ptr(rd_ptr, i_word_count);
      rd_pend <= rd_pend + {1'b0, rd_inc} - {1'b0, rd_dec};
      if (pop || empty)                       streak <= '0;
      else if (rd_dec && streak != STREAK_MAX) streak <= streak + 1'b1;
      if (ovf_now) o_overflow <= 1'b1;
    end
  end

  // Stage p0: command on the SRAM pins; stage p1: read word captured into o_rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sram_cen  <= 1'b1;
      o_sram_wen  <= 1'b1;
      o_sram_addr <= '0;
      o_sram_d    <= '0;
      rd_vld_p0   <= 1'b0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
    end else begin
      rd_vld_p0  <= rd_dec;
      o_rd_valid <= rd_vld_p0 && !i_init;
      if (rd_vld_p0) o_rd_data <= i_sram_q;
      o_sram_cen <= (gnt == GNT_IDLE);
      o_sram_wen <= !(gnt == GNT_LOAD || gnt == GNT_STORE);
      case (gnt)
        GNT_LOAD: begin
          o_sram_addr <= i_ld_addr;
          o_sram_d    <= i_ld_data;
        end
        GNT_STORE: begin
          o_sram_addr <= head_addr;
          o_sram_d    <= head_data;
        end
        GNT_READ: o_sram_addr <= rd_ptr;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, pin/return monitors and per-scenario tasks.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW     = MAX_T_SIZE_LOG;
  localparam int WW     = SRAM_WORD;
  localparam int NWORDS = 1 << AW;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          init       = 1'b0;
  logic          load_mode  = 1'b0;
  logic [AW-1:0] word_count = '0;
  logic          ld_valid   = 1'b0;
  logic [AW-1:0] ld_addr    = '0;
  logic [WW-1:0] ld_data    = '0;
  logic          rd_req     = 1'b0;
  logic          wr_req     = 1'b0;
  logic [WW-1:0] wr_data    = '0;
  logic          preload    = 1'b0;
  logic          ld_ready;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_d;
  logic [WW-1:0] sram_q;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WW-1:0] mem [NWORDS];
  logic          cmd_wen  [$];
  logic [AW-1:0] cmd_addr [$];
  logic [WW-1:0] cmd_d    [$];
  int            cmd_cyc  [$];
  logic [WW-1:0] rv_data  [$];
  int            rv_cyc   [$];

  sram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_init       (init),
    .i_load_mode  (load_mode),
    .i_word_count (word_count),
    .i_ld_valid   (ld_valid),
    .i_ld_addr    (ld_addr),
    .i_ld_data    (ld_data),
    .o_ld_ready   (ld_ready),
    .i_rd_req     (rd_req),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .i_wr_req     (wr_req),
    .i_wr_data    (wr_data),
    .o_sram_cen   (sram_cen),
    .o_sram_wen   (sram_wen),
    .o_sram_addr  (sram_addr),
    .o_sram_d     (sram_d),
    .i_sram_q     (sram_q),
    .o_busy       (busy),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: word n holds n after preload; reads present the addressed word during the command cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= WW'(i);
    end else if (!sram_cen && !sram_wen) begin
      mem[sram_addr] <= sram_d;
    end
  end
  assign sram_q = mem[sram_addr];

  always @(negedge clk) begin
    if (!sram_cen) begin
      cmd_wen.push_back(sram_wen);
      cmd_addr.push_back(sram_addr);
      cmd_d.push_back(sram_d);
      cmd_cyc.push_back(cyc);
    end
    if (rd_valid) begin
      rv_data.push_back(rd_data);
      rv_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    step(1);
    init = 1'b0;
  endtask

  task automatic refill();
    preload = 1'b1;
    step(1);
    preload = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain busy=%0b expected 0 after %0d cycles", name, busy, n);
    end
    step(3);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    preload = 1'b1;
    step(2);
    preload = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_cen, sram_wen, rd_valid, ld_ready, busy, overflow} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 110000",
               {sram_cen, sram_wen, rd_valid, ld_ready, busy, overflow});
    end
    checks++;
    if (sram_addr !== '0 || sram_d !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h d=%h rd=%h expected 0", sram_addr, sram_d, rd_data);
    end
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_load_mode();
    int base_c = cmd_wen.size();
    int base_r = rv_data.size();
    int c2, nrd, ri;
    load_mode = 1'b1;
    ld_valid  = 1'b1;
    ld_addr   = AW'(5);
    ld_data   = WW'(16'h00A5);
    rd_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready got %b expected 1", ld_ready);
    end
    step(1);
    ld_valid = 1'b0;
    rd_req   = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_cen, sram_wen} !== 2'b00 || sram_addr !== AW'(5) || sram_d !== WW'(16'h00A5)) begin
      errors++;
      $display("FAIL load_pins cen=%b wen=%b addr=%h d=%h expected 0 0 05 00a5",
               sram_cen, sram_wen, sram_addr, sram_d);
    end
    step(3);
    nrd = 0;
    for (int i = base_c; i < cmd_wen.size(); i++) if (cmd_wen[i]) nrd++;
    checks++;
    if (nrd != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_hold reads=%0d busy=%b expected 0 reads busy 1", nrd, busy);
    end
    load_mode = 1'b0;
    ld_valid  = 1'b1;
    c2 = cyc;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_ready_off got %b expected 0", ld_ready);
    end
    step(1);
    ld_valid = 1'b0;
    step(4);
    nrd = 0;
    ri  = -1;
    for (int i = base_c; i < cmd_wen.size(); i++) if (cmd_wen[i]) begin nrd++; ri = i; end
    checks++;
    if (nrd != 1 || ri < 0) begin
      errors++;
      $display("FAIL load_release_count reads=%0d expected 1", nrd);
    end else begin
      checks++;
      if (cmd_addr[ri] !== '0 || cmd_cyc[ri] != c2 + 1) begin
        errors++;
        $display("FAIL load_release_read addr=%h cyc=%0d expected 00 cyc %0d",
                 cmd_addr[ri], cmd_cyc[ri], c2 + 1);
      end
    end
    checks++;
    if (rv_data.size() != base_r + 1) begin
      errors++;
      $display("FAIL load_release_rv count=%0d expected 1", rv_data.size() - base_r);
    end else if (rv_data[base_r] !== '0 || rv_cyc[base_r] != c2 + 2) begin
      errors++;
      $display("FAIL load_release_rv data=%h cyc=%0d expected 0000 cyc %0d",
               rv_data[base_r], rv_cyc[base_r], c2 + 2);
    end
  endtask

  task automatic test_read_latency();
    int base_r, pcyc[3];
    refill();
    do_init();
    base_r = rv_data.size();
    for (int k = 0; k < 3; k++) begin
      rd_req  = 1'b1;
      pcyc[k] = cyc;
      step(1);
    end
    rd_req = 1'b0;
    step(6);
    checks++;
    if (rv_data.size() != base_r + 3) begin
      errors++;
      $display("FAIL latency_count got %0d expected 3", rv_data.size() - base_r);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rv_data[base_r+k] !== WW'(k) || rv_cyc[base_r+k] != pcyc[k] + 3) begin
          errors++;
          $display("FAIL latency_word%0d data=%h cyc=%0d expected %h cyc %0d", k,
                   rv_data[base_r+k], rv_cyc[base_r+k], WW'(k), pcyc[k] + 3);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base_c, base_r, n;
    refill();
    do_init();
    word_count = AW'(3);
    base_c = cmd_wen.size();
    base_r = rv_data.size();
    for (int k = 0; k < 6; k++) begin
      rd_req = 1'b1;
      step(1);
      rd_req = 1'b0;
      step(1);
    end
    drain("wrap");
    n = 0;
    for (int i = base_c; i < cmd_wen.size(); i++) begin
      checks++;
      if (cmd_wen[i] !== 1'b1 || cmd_addr[i] !== AW'(n % 3)) begin
        errors++;
        $display("FAIL wrap_addr%0d wen=%b addr=%h expected read at %h", n, cmd_wen[i],
                 cmd_addr[i], AW'(n % 3));
      end
      n++;
    end
    checks++;
    if (n != 6 || rv_data.size() != base_r + 6) begin
      errors++;
      $display("FAIL wrap_count cmds=%0d returns=%0d expected 6 6", n, rv_data.size() - base_r);
    end
    word_count = '0;
  endtask

  task automatic test_raw_hazard();
    int base_c, base_r;
    refill();
    do_init();
    base_c  = cmd_wen.size();
    base_r  = rv_data.size();
    wr_req  = 1'b1;
    wr_data = WW'(16'h1234);
    for (int k = 0; k < 6; k++) begin
      rd_req = 1'b1;
      step(1);
      wr_req = 1'b0;
    end
    rd_req = 1'b0;
    drain("raw");
    checks++;
    if (cmd_wen.size() != base_c + 7) begin
      errors++;
      $display("FAIL raw_cmds got %0d expected 7", cmd_wen.size() - base_c);
    end else if (cmd_wen[base_c] !== 1'b0 || cmd_addr[base_c] !== '0 ||
                 cmd_d[base_c] !== WW'(16'h1234)) begin
      errors++;
      $display("FAIL raw_first wen=%b addr=%h d=%h expected store 00 1234",
               cmd_wen[base_c], cmd_addr[base_c], cmd_d[base_c]);
    end
    checks++;
    if (rv_data.size() != base_r + 6) begin
      errors++;
      $display("FAIL raw_returns got %0d expected 6", rv_data.size() - base_r);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (rv_data[base_r+k] !== ((k == 0) ? WW'(16'h1234) : WW'(k))) begin
          errors++;
          $display("FAIL raw_word%0d got %h expected %h", k, rv_data[base_r+k],
                   (k == 0) ? WW'(16'h1234) : WW'(k));
        end
      end
    end
  endtask

  task automatic test_streak();
    int base_c, base_r, scyc, wi, nrd;
    refill();
    do_init();
    base_c = cmd_wen.size();
    base_r = rv_data.size();
    scyc   = 0;
    for (int k = 0; k < 12; k++) begin
      rd_req = 1'b1;
      if (k == 2) begin
        wr_req  = 1'b1;
        wr_data = WW'(16'hBEEF);
        scyc    = cyc;
      end
      step(1);
      wr_req = 1'b0;
    end
    rd_req = 1'b0;
    drain("streak");
    wi  = -1;
    nrd = 0;
    for (int i = base_c; i < cmd_wen.size(); i++) begin
      if (wi < 0 && !cmd_wen[i]) wi = i;
      else if (wi < 0 && cmd_cyc[i] >= scyc + 2) nrd++;
    end
    checks++;
    if (wi < 0) begin
      errors++;
      $display("FAIL streak_store got none expected one store");
    end else if (nrd > READ_STREAK_DEFAULT || cmd_addr[wi] !== '0 || cmd_d[wi] !== WW'(16'hBEEF)) begin
      errors++;
      $display("FAIL streak_store reads_before=%0d addr=%h d=%h expected <=%0d 00 beef",
               nrd, cmd_addr[wi], cmd_d[wi], READ_STREAK_DEFAULT);
    end
    checks++;
    if (rv_data.size() != base_r + 12) begin
      errors++;
      $display("FAIL streak_returns got %0d expected 12", rv_data.size() - base_r);
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (rv_data[base_r+k] !== WW'(k)) begin
          errors++;
          $display("FAIL streak_word%0d got %h expected %h", k, rv_data[base_r+k], WW'(k));
        end
      end
    end
  endtask

  task automatic test_overflow();
    int base_c, base_r, nrd, nwr;
    refill();
    do_init();
    base_c    = cmd_wen.size();
    base_r    = rv_data.size();
    load_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_req  = 1'b1;
      wr_data = WW'(16'h0100 + k);
      step(1);
    end
    wr_data = WW'(16'h0104);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill overflow=%b busy=%b expected 0 1", overflow, busy);
    end
    step(1);
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_store got %b expected 1", overflow);
    end
    step(1);
    do_init();
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_init_clear got %b expected 0", overflow);
    end
    step(1);
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1;
      step(1);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_rdpend_3 got %b expected 0", overflow);
    end
    step(1);
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_rdpend_4 got %b expected 1", overflow);
    end
    step(1);
    load_mode = 1'b0;
    drain("ovf_reads");
    wr_req  = 1'b1;
    wr_data = WW'(16'hBEEF);
    step(1);
    wr_req = 1'b0;
    drain("ovf_store");
    nrd = 0;
    nwr = 0;
    for (int i = base_c; i < cmd_wen.size(); i++) begin
      if (cmd_wen[i]) begin
        checks++;
        if (cmd_addr[i] !== AW'(nrd)) begin
          errors++;
          $display("FAIL ovf_read%0d addr=%h expected %h", nrd, cmd_addr[i], AW'(nrd));
        end
        nrd++;
      end else begin
        checks++;
        if (cmd_addr[i] !== '0 || cmd_d[i] !== WW'(16'hBEEF)) begin
          errors++;
          $display("FAIL ovf_post_init_store addr=%h d=%h expected 00 beef", cmd_addr[i], cmd_d[i]);
        end
        nwr++;
      end
    end
    checks++;
    if (nrd != 3 || nwr != 1 || rv_data.size() != base_r + 3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_totals reads=%0d stores=%0d returns=%0d overflow=%b expected 3 1 3 1",
               nrd, nwr, rv_data.size() - base_r, overflow);
    end
    do_init();
  endtask

  task automatic test_init_discard();
    int base_c, base_r;
    refill();
    do_init();
    base_c = cmd_wen.size();
    base_r = rv_data.size();
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    step(1);
    init = 1'b1;
    step(1);
    init = 1'b0;
    step(4);
    checks++;
    if (cmd_wen.size() != base_c + 1 || rv_data.size() != base_r) begin
      errors++;
      $display("FAIL init_discard cmds=%0d returns=%0d expected 1 0",
               cmd_wen.size() - base_c, rv_data.size() - base_r);
    end
  endtask

  task automatic test_reset_mid_read();
    int base_r, rel;
    do_init();
    rd_req = 1'b1;
    step(1);
    step(1);
    rd_req = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_cen, sram_wen, rd_valid, busy} !== 4'b1100 || sram_addr !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid cen=%b wen=%b vld=%b busy=%b addr=%h rd=%h expected 1 1 0 0 00 0000",
               sram_cen, sram_wen, rd_valid, busy, sram_addr, rd_data);
    end
    step(2);
    rst_n  = 1'b1;
    rel    = cyc;
    base_r = rv_data.size();
    step(6);
    checks++;
    if (rv_data.size() != base_r) begin
      errors++;
      $display("FAIL reset_mid_no_valid returns=%0d after cycle %0d expected 0",
               rv_data.size() - base_r, rel);
    end
  endtask

  task automatic test_random();
    logic [WW-1:0] sm [NWORDS];
    logic [WW-1:0] exp_q [$];
    int wc, ns, nr, base_r, gap;
    for (int it = 0; it < 3; it++) begin
      refill();
      do_init();
      wc = $urandom_range(4, 12);
      word_count = AW'(wc);
      for (int a = 0; a < NWORDS; a++) sm[a] = WW'(a);
      ns = $urandom_range(1, wc + 3);
      for (int k = 0; k < ns; k++) begin
        wr_req  = 1'b1;
        wr_data = WW'($urandom);
        sm[k % wc] = wr_data;
        step(1);
        wr_req = 1'b0;
        gap = $urandom_range(0, 2);
        if (gap > 0) step(gap);
      end
      drain("rand_store");
      exp_q.delete();
      base_r = rv_data.size();
      nr = $urandom_range(wc, 2 * wc);
      for (int j = 0; j < nr; j++) begin
        rd_req = 1'b1;
        exp_q.push_back(sm[j % wc]);
        step(1);
        rd_req = 1'b0;
        gap = $urandom_range(0, 2);
        if (gap > 0) step(gap);
      end
      drain("rand_read");
      checks++;
      if (rv_data.size() != base_r + nr) begin
        errors++;
        $display("FAIL rand%0d_count got %0d expected %0d", it, rv_data.size() - base_r, nr);
      end else begin
        for (int j = 0; j < nr; j++) begin
          checks++;
          if (rv_data[base_r+j] !== exp_q[j]) begin
            errors++;
            $display("FAIL rand%0d_word%0d got %h expected %h", it, j, rv_data[base_r+j], exp_q[j]);
          end
        end
      end
    end
    word_count = '0;
  endtask

  initial begin
    test_reset();
    test_load_mode();
    test_read_latency();
    test_wrap();
    test_raw_hazard();
    test_streak();
    test_overflow();
    test_init_discard();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
